fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 64: instruction-memory size in words; the PC wraps modulo 4*DEPTH bytes.
REQ-003 Parameter HALT_ON_ZERO, default 1: when 1, a fetched word equal to 32'h0 is treated as end-of-program.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 en  input  1  fetch enable.
REQ-007 redirect_valid  input  1  branch/jump redirect request.
REQ-008 redirect_pc  input  32  redirect target; bits [1:0] are ignored.
REQ-009 imem_a  output  32  byte address to instruction memory; word-aligned.
REQ-010 imem_rd  input  32  instruction-memory read data, combinational from imem_a in the same cycle.
REQ-011 out_valid  output  1  head instruction available.
REQ-012 out_instr  output  32  head instruction word.
REQ-013 out_pc  output  32  byte address of the head instruction.
REQ-014 out_ready  input  1  consumer accepts the head.
REQ-015 halted  output  1  sequencer is in state HALT.
REQ-016 retired_cnt  output  32  count of accepted instructions; wraps 0xFFFF_FFFF to 0.

Function
REQ-017 The block SHALL hold a PC register and drive imem_a = {pc[31:2], 2'b00} combinationally in every state.
REQ-018 The block SHALL hold a 2-entry in-order buffer of {pc, instr} pairs.
- out_valid = (count != 0).
- out_instr/out_pc show the head entry; both read 0 when the buffer is empty.
REQ-019 A pop SHALL occur when out_valid && out_ready are both 1 at the clock edge.
REQ-020 The FSM states SHALL be IDLE, RUN and HALT.
REQ-021 FSM transitions SHALL be:
- IDLE->RUN when en=1.
- RUN->IDLE when en=0.
- RUN->HALT when a halt word is fetched.
- HALT holds until a redirect.
REQ-022 A fetch SHALL occur in RUN when (count - pop) < 2 and redirect_valid=0; the pair {pc, imem_rd} is written to the buffer tail at that edge.
REQ-023 Fetch latency: a word fetched at edge N SHALL be visible on the outputs after edge N, with out_valid=1 from that cycle.
REQ-024 A fetch SHALL advance pc by 4, with pc = 4*DEPTH-4 wrapping to 0.
REQ-025 When HALT_ON_ZERO=1 and imem_rd=0 on a fetch, the block SHALL:
- not enqueue the word;
- hold pc at that address;
- enter HALT, in which the buffer keeps draining.
REQ-026 redirect_valid=1 SHALL take priority over fetch and halt at the edge:
- flush the buffer (count=0);
- set pc = {redirect_pc[31:2], 2'b00} modulo 4*DEPTH;
- perform no fetch that cycle;
- next state is RUN if en=1, else IDLE (from any state, including HALT).
REQ-027 A redirect coinciding with a pop SHALL count the pop in retired_cnt and still flush the buffer.
REQ-028 When en=0, the block SHALL fetch nothing and the buffer SHALL continue draining.
REQ-029 retired_cnt SHALL increment by 1 on each pop.

Reset
REQ-030 While rst_n=0, the block SHALL asynchronously set:
- state=IDLE, pc=RESET_PC, count=0;
- out_valid=0, out_instr=0, out_pc=0;
- halted=0, retired_cnt=0.
REQ-031 The first fetch after reset SHALL occur no earlier than the second rising edge after rst_n deasserts with en=1 (IDLE->RUN, then fetch).

Verification
REQ-032 Memory holds [0]=E3A0204B, [1]=E04F000F, [2]=E3A04055, rest 0; en=1, out_ready=1 -> accepted (out_pc,out_instr) = (0,E3A0204B), (4,E04F000F), (8,E3A04055); then halted=1, imem_a=0xC, out_valid=0, retired_cnt=3.
REQ-033 Same memory, out_ready=0 -> buffer holds pc 0 and 4; imem_a stays 0x8; head stays (0,E3A0204B). Then out_ready=1 -> all three words delivered in order, no loss, no duplication.
REQ-034 While halted, redirect_valid=1 with redirect_pc=0x6 -> halted=0; next accepted is (4,E04F000F).
REQ-035 Buffer full, out_ready=1 and redirect to 0x8 on the same edge -> retired_cnt+1; buffer flushed; next accepted is (8,E3A04055).
REQ-036 HALT_ON_ZERO=0, redirect to 0xFC -> accepted out_pc sequence is 0xFC then 0x000.
REQ-037 rst_n pulled low mid-stream, between clock edges -> out_valid=0, imem_a=RESET_PC, retired_cnt=0 immediately, before the next edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Instruction fetch front end: walks a PC through a word-addressed
// instruction memory and queues {pc, instr} pairs in a two-entry
// in-order buffer for a downstream consumer. Redirects flush the
// buffer and restart fetch. Optionally, a zero word stops fetch.
//
// Ports
//   clk            clock; all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   en             fetch enable
//   redirect_valid branch/jump redirect request (wins over fetch/halt)
//   redirect_pc    redirect target byte address (bits [1:0] ignored)
//   imem_a         word-aligned byte address to instruction memory
//   imem_rd        instruction memory read data (combinational from imem_a)
//   out_valid      head instruction available
//   out_instr      head instruction word (0 when empty)
//   out_pc         head instruction byte address (0 when empty)
//   out_ready      consumer accepts the head this cycle
//   halted         sequencer stopped on a zero word
//   retired_cnt    number of accepted instructions (wraps)
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DEPTH        = 64,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_rd,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        halted,
  output logic [31:0] retired_cnt
);

  localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] b0_pc_q, b0_pc_d, b0_instr_q, b0_instr_d;
  logic [31:0] b1_pc_q, b1_pc_d, b1_instr_q, b1_instr_d;
  logic [31:0] retired_q, retired_d;

  logic        pop;
  logic [1:0]  count_after_pop;
  logic        fetch;
  logic        halt_hit;
  logic        push;
  logic [31:0] pc_aligned;
  logic [31:0] pc_next;
  logic [31:0] redir_aligned;

  assign pc_aligned      = pc_q & 32'hFFFF_FFFC;
  assign redir_aligned   = redirect_pc & 32'hFFFF_FFFC;
  assign pc_next         = (pc_aligned >= (MEM_BYTES - 32'd4)) ? 32'd0 : (pc_aligned + 32'd4);
  assign pop             = (count_q != 2'd0) && out_ready;
  // Space is judged after this edge's pop so a full buffer can refill while draining.
  assign count_after_pop = count_q - {1'b0, pop};
  assign fetch           = (state_q == RUN) && en && !redirect_valid && (count_after_pop < 2'd2);
  assign halt_hit        = fetch && HALT_ON_ZERO && (imem_rd == 32'h0000_0000);
  assign push            = fetch && !halt_hit;

  assign imem_a      = pc_aligned;
  assign out_valid   = (count_q != 2'd0);
  assign out_instr   = (count_q != 2'd0) ? b0_instr_q : 32'h0000_0000;
  assign out_pc      = (count_q != 2'd0) ? b0_pc_q : 32'h0000_0000;
  assign halted      = (state_q == HALT);
  assign retired_cnt = retired_q;

  // Next-state logic; a redirect overrides every state, including HALT.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = en ? RUN : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (en) state_d = RUN;
          else    state_d = IDLE;
        end
        RUN: begin
          if (!en)          state_d = IDLE;
          else if (halt_hit) state_d = HALT;
          else              state_d = RUN;
        end
        HALT:    state_d = HALT;
        default: state_d = IDLE;
      endcase
    end
  end

  // PC, buffer and retire-counter update; a pop always retires, even under a flush.
  always_comb begin
    pc_d       = pc_q;
    count_d    = count_q;
    b0_pc_d    = b0_pc_q;
    b0_instr_d = b0_instr_q;
    b1_pc_d    = b1_pc_q;
    b1_instr_d = b1_instr_q;
    retired_d  = retired_q + {31'd0, pop};
    if (redirect_valid) begin
      count_d = 2'd0;
      pc_d    = redir_aligned % MEM_BYTES;
    end else begin
      count_d = count_after_pop + {1'b0, push};
      if (pop) begin
        b0_pc_d    = b1_pc_q;
        b0_instr_d = b1_instr_q;
      end else begin
        b0_pc_d    = b0_pc_q;
        b0_instr_d = b0_instr_q;
      end
      if (push) begin
        pc_d = pc_next;
        // Tail slot is whichever entry follows the surviving contents.
        if (count_after_pop == 2'd0) begin
          b0_pc_d    = pc_aligned;
          b0_instr_d = imem_rd;
        end else begin
          b1_pc_d    = pc_aligned;
          b1_instr_d = imem_rd;
        end
      end else begin
        pc_d = pc_q;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      b0_pc_q    <= 32'h0000_0000;
      b0_instr_q <= 32'h0000_0000;
      b1_pc_q    <= 32'h0000_0000;
      b1_instr_q <= 32'h0000_0000;
      retired_q  <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      b0_pc_q    <= b0_pc_d;
      b0_instr_q <= b0_instr_d;
      b1_pc_q    <= b1_pc_d;
      b1_instr_q <= b1_instr_d;
      retired_q  <= retired_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
// Directed and randomized bench for fetch_sequencer. The main instance
// uses default parameters and is tracked every cycle by a queue-based
// reference model; a second instance with HALT_ON_ZERO=0 covers the
// wrap-around case.
module tb_fetch_sequencer;

  localparam int unsigned MEMB = 256;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en, redirect_valid, out_ready;
  logic [31:0] redirect_pc, imem_a, imem_rd, out_instr, out_pc, retired_cnt;
  logic        out_valid, halted;
  logic [31:0] mem [64];

  logic        en2, rv2, rdy2;
  logic [31:0] rpc2, a2, rd2, i2, p2, r2;
  logic        v2, h2;
  logic [31:0] mem2 [64];

  assign imem_rd = mem[imem_a[7:2]];
  assign rd2     = mem2[a2[7:2]];

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_a(imem_a), .imem_rd(imem_rd),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .halted(halted), .retired_cnt(retired_cnt)
  );

  fetch_sequencer #(.HALT_ON_ZERO(1'b0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .en(en2), .redirect_valid(rv2),
    .redirect_pc(rpc2), .imem_a(a2), .imem_rd(rd2),
    .out_valid(v2), .out_instr(i2), .out_pc(p2),
    .out_ready(rdy2), .halted(h2), .retired_cnt(r2)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_run, m_halt;
  logic [31:0] m_ret;
  ent_t        mq[$];
  ent_t        acc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_run = 1'b0; m_halt = 1'b0; m_ret = 32'h0;
    mq.delete();
  endtask

  task automatic chk_model();
    ent_t h;
    h = (mq.size() != 0) ? mq[0] : ent_t'(64'h0);
    chk("imem_a", imem_a, m_pc);
    chk("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
    chk("out_instr", out_instr, h.instr);
    chk("out_pc", out_pc, h.pc);
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("retired_cnt", retired_cnt, m_ret);
  endtask

  task automatic model_update(input logic e, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic [31:0] w;
    w = mem[m_pc[7:2]];
    if (mq.size() != 0 && rdy) begin
      void'(mq.pop_front());
      m_ret = m_ret + 32'd1;
    end
    if (rv) begin
      mq.delete();
      m_pc   = (rpc & 32'hFFFF_FFFC) % MEMB;
      m_run  = e;
      m_halt = 1'b0;
    end else if (m_halt) begin
      m_halt = 1'b1;
    end else if (!m_run) begin
      m_run = e;
    end else if (!e) begin
      m_run = 1'b0;
    end else if (mq.size() < 2) begin
      if (w == 32'h0) begin
        m_halt = 1'b1;
        m_run  = 1'b0;
      end else begin
        mq.push_back({m_pc, w});
        m_pc = (m_pc + 32'd4) % MEMB;
      end
    end
  endtask

  // One cycle: drive at negedge, check just after, advance model across the edge.
  task automatic step(input logic e, input logic rv, input logic [31:0] rpc, input logic rdy);
    en = e; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    #1;
    chk_model();
    if (out_valid && out_ready) acc.push_back({out_pc, out_instr});
    model_update(e, rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    #1;
    model_reset();
    chk_model();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]  = 32'h0;
      mem2[i] = 32'hA500_0000 + 32'(i);
    end
    mem[0] = 32'hE3A0204B; mem[1] = 32'hE04F000F; mem[2] = 32'hE3A04055;
    en2 = 1'b0; rv2 = 1'b0; rpc2 = 32'h0; rdy2 = 1'b1;
    apply_reset();

    // Wrap-around with zero-halt disabled: 0xFC then 0x000.
    en2 = 1'b1; rv2 = 1'b1; rpc2 = 32'h0000_00FC;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    rv2 = 1'b0;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("nz_valid", {31'd0, v2}, 32'd1);
    chk("nz_pc_fc", p2, 32'h0000_00FC);
    chk("nz_instr_fc", i2, 32'hA500_003F);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("nz_pc_wrap", p2, 32'h0000_0000);
    chk("nz_instr_wrap", i2, 32'hA500_0000);
    chk("nz_retired", r2, 32'd1);
    en2 = 1'b0;

    // Straight-line program, consumer always ready.
    acc.delete();
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("run_acc_n", 32'(acc.size()), 32'd3);
    chk("run_acc0", acc[0].pc, 32'h0);  chk("run_acc0i", acc[0].instr, 32'hE3A0204B);
    chk("run_acc1", acc[1].pc, 32'h4);  chk("run_acc1i", acc[1].instr, 32'hE04F000F);
    chk("run_acc2", acc[2].pc, 32'h8);  chk("run_acc2i", acc[2].instr, 32'hE3A04055);
    chk("run_halted", {31'd0, halted}, 32'd1);
    chk("run_imem_a", imem_a, 32'hC);
    chk("run_valid", {31'd0, out_valid}, 32'd0);
    chk("run_retired", retired_cnt, 32'd3);

    // Redirect out of HALT to a misaligned target.
    acc.delete();
    step(1'b1, 1'b1, 32'h6, 1'b1);
    chk("redir_unhalt", {31'd0, halted}, 32'd0);
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("redir_acc0", acc[0].pc, 32'h4);
    chk("redir_acc0i", acc[0].instr, 32'hE04F000F);

    // Back-pressure: buffer fills and fetch stalls.
    apply_reset();
    acc.delete();
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("bp_imem_a", imem_a, 32'h8);
    chk("bp_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_pc", out_pc, 32'h0);
    chk("bp_instr", out_instr, 32'hE3A0204B);
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("bp_acc_n", 32'(acc.size()), 32'd3);
    chk("bp_acc0", acc[0].pc, 32'h0);
    chk("bp_acc1", acc[1].pc, 32'h4);
    chk("bp_acc2", acc[2].pc, 32'h8);

    // Redirect on the same edge as a pop from a full buffer.
    step(1'b1, 1'b1, 32'h0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    acc.delete();
    step(1'b1, 1'b1, 32'h8, 1'b1);
    chk("flush_retired", retired_cnt, 32'd4);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_imem_a", imem_a, 32'h8);
    acc.delete();
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b1);
    chk("flush_acc0", acc[0].pc, 32'h8);
    chk("flush_acc0i", acc[0].instr, 32'hE3A04055);

    // Randomized traffic against the model, with an async reset mid-stream.
    for (int i = 0; i < 64; i++) begin
      mem[i] = (($urandom % 6) == 0) ? 32'h0 : ($urandom | 32'h1);
    end
    for (int i = 0; i < 400; i++) begin
      step((($urandom % 8) != 0), (($urandom % 10) == 0), $urandom, (($urandom % 3) != 0));
      if (i == 200) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_imem_a", imem_a, 32'h0);
        chk("arst_retired", retired_cnt, 32'd0);
        model_reset();
        chk_model();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
